// File: rtl/mario_sound_mixer.sv
// Final audio mix: four channels with 4-bit gains, one shared multiplier, saturation to 16 bits.
// Optional DC-blocking high-pass stage enabled by defining MIXER_DCBLOCK_EN.
module mario_sound_mixer #(
    parameter int DIV   = 1000,
    parameter int ACC_W = 24
) (
    input  logic        I_CLK_48M,
    input  logic        I_RESETn,
    input  logic [15:0] I_WAV0,
    input  logic [15:0] I_WAV1,
    input  logic [15:0] I_WAV2,
    input  logic [7:0]  I_DIG,
    input  logic [15:0] I_GAIN,
    input  logic        I_MUTE,
    output logic [15:0] O_SND,
    output logic        O_SND_STB,
    output logic        O_CLIP
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC0 = 3'd1;
    localparam logic [2:0] S_MAC1 = 3'd2;
    localparam logic [2:0] S_MAC2 = 3'd3;
    localparam logic [2:0] S_MAC3 = 3'd4;
    localparam logic [2:0] S_SAT  = 3'd5;
`ifdef MIXER_DCBLOCK_EN
    localparam logic [2:0] S_DCB  = 3'd6;
    localparam logic signed [17:0] Y_MAX = 18'sd32767;
    localparam logic signed [17:0] Y_MIN = -18'sd32768;
`endif

    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-32768);

    logic [11:0]              cnt;
    logic                     tick;
    logic [2:0]               state;
    logic signed [15:0]       wav0_q, wav1_q, wav2_q, dig_q;
    logic [15:0]              gain_q;
    logic                     mute_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  s;
    logic signed [15:0]       mul_a;
    logic [3:0]               mul_g;
    logic signed [4:0]        mul_g5;
    logic signed [20:0]       prod;
    logic signed [15:0]       sat_res;
    logic                     sat_clip;

    assign tick = (cnt == 12'(DIV - 1));

    // Single multiplier shared across the four MAC cycles.
    always_comb begin
        mul_a = wav0_q;
        mul_g = gain_q[3:0];
        case (state)
            S_MAC1:  begin mul_a = wav1_q; mul_g = gain_q[7:4];   end
            S_MAC2:  begin mul_a = wav2_q; mul_g = gain_q[11:8];  end
            S_MAC3:  begin mul_a = dig_q;  mul_g = gain_q[15:12]; end
            default: ;
        endcase
    end

    assign mul_g5 = $signed({1'b0, mul_g});
    assign prod   = 21'(mul_a) * 21'(mul_g5);
    assign s      = acc >>> 3;

    always_comb begin
        sat_res  = s[15:0];
        sat_clip = 1'b0;
        if (mute_q) begin
            sat_res = '0;
        end else if (s > S_MAX) begin
            sat_res  = 16'sh7fff;
            sat_clip = 1'b1;
        end else if (s < S_MIN) begin
            sat_res  = -16'sh8000;
            sat_clip = 1'b1;
        end
    end

`ifdef MIXER_DCBLOCK_EN
    logic signed [15:0] x_q, x_prev, y_prev, y_sat;
    logic signed [17:0] y18;

    // One-pole high-pass: pole at 1 - 1/256.
    assign y18 = 18'(x_q) - 18'(x_prev) + 18'(y_prev) - 18'(y_prev >>> 8);

    always_comb begin
        y_sat = y18[15:0];
        if (y18 > Y_MAX)      y_sat = 16'sh7fff;
        else if (y18 < Y_MIN) y_sat = -16'sh8000;
    end
`endif

    always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
        if (!I_RESETn) begin
            cnt       <= '0;
            state     <= S_IDLE;
            wav0_q    <= '0;
            wav1_q    <= '0;
            wav2_q    <= '0;
            dig_q     <= '0;
            gain_q    <= '0;
            mute_q    <= 1'b0;
            acc       <= '0;
            O_SND     <= '0;
            O_SND_STB <= 1'b0;
            O_CLIP    <= 1'b0;
`ifdef MIXER_DCBLOCK_EN
            x_q       <= '0;
            x_prev    <= '0;
            y_prev    <= '0;
`endif
        end else begin
            cnt       <= tick ? 12'd0 : cnt + 12'd1;
            O_SND_STB <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        wav0_q <= I_WAV0;
                        wav1_q <= I_WAV1;
                        wav2_q <= I_WAV2;
                        // Offset-binary DAC code to signed, scaled to 16 bits.
                        dig_q  <= {~I_DIG[7], I_DIG[6:0], 8'h00};
                        gain_q <= I_GAIN;
                        mute_q <= I_MUTE;
                        acc    <= '0;
                        state  <= S_MAC0;
                    end
                end
                S_MAC0, S_MAC1, S_MAC2, S_MAC3: begin
                    acc   <= acc + ACC_W'(prod);
                    state <= state + 3'd1;
                end
                S_SAT: begin
                    O_CLIP <= O_CLIP | sat_clip;
`ifdef MIXER_DCBLOCK_EN
                    x_q    <= sat_res;
                    state  <= S_DCB;
`else
                    O_SND     <= sat_res;
                    O_SND_STB <= 1'b1;
                    state     <= S_IDLE;
`endif
                end
`ifdef MIXER_DCBLOCK_EN
                S_DCB: begin
                    O_SND     <= y_sat;
                    O_SND_STB <= 1'b1;
                    x_prev    <= x_q;
                    y_prev    <= y_sat;
                    state     <= S_IDLE;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mario_sound_mixer.md
Name: mario_sound_mixer

Overview:
- Final audio mixing stage, directly downstream of the analogue-sample block.
- Consumes the three signed 16-bit sample streams (skid, Mario run, Luigi run) plus the 8-bit i8035 DAC output.
- Applies a per-channel 4-bit gain through one shared multiplier in a small MAC sequencer, then saturates.
- Emits one signed 16-bit mono sample per output-rate strobe to the platform audio serializer.

Parameters:
- DIV, 1000, output sample period in I_CLK_48M cycles (48 kHz). Legal range 16..4095.
- ACC_W, 24, accumulator width in bits (signed).

Ports:
- I_CLK_48M  in  1  system clock
- I_RESETn  in  1  reset
- I_WAV0  in  16  signed skid sample
- I_WAV1  in  16  signed Mario run sample
- I_WAV2  in  16  signed Luigi run sample
- I_DIG  in  8  unsigned i8035 DAC value; 0x80 = silence
- I_GAIN  in  16  packed gains: [3:0] WAV0, [7:4] WAV1, [11:8] WAV2, [15:12] DIG
- I_MUTE  in  1  force output to zero
- O_SND  out  16  signed mixed sample
- O_SND_STB  out  1  one-cycle pulse when O_SND updates
- O_CLIP  out  1  sticky clip flag

Behaviour:
- Interface: reset I_RESETn, asynchronous, active-low; clock I_CLK_48M.
- Reset values: O_SND=0, O_SND_STB=0, O_CLIP=0. Divider, accumulator, snapshot registers and FSM state are also cleared; FSM enters IDLE.
- Divider: counts 0..DIV-1 and wraps to 0. Terminal count produces an internal tick.
- Tick in IDLE:
  - Snapshot I_WAV0..2, I_GAIN and I_MUTE.
  - Convert I_DIG to signed: (I_DIG - 128) << 8.
  - Clear the accumulator; go to MAC0.
- Ticks arriving outside IDLE cannot occur when DIV ≥ 16; none are queued.
- FSM: IDLE -> MAC0 -> MAC1 -> MAC2 -> MAC3 -> SAT -> IDLE.
- MACn (n = 0..3, MAC3 = DIG): acc <= acc + sample_n * gain_n.
  - Gain is unsigned 0..15 with 8 = unity.
  - Product is 21-bit signed, sign-extended to ACC_W.
  - One multiplication per cycle.
- SAT:
  - s = acc >>> 3 (arithmetic shift).
  - If s > 32767, result = 32767 and O_CLIP <= 1. If s < -32768, result = -32768 and O_CLIP <= 1. Otherwise result = s[15:0].
  - If the snapshot mute is set, result = 0 and O_CLIP is not set.
  - O_SND <= result; O_SND_STB <= 1 for exactly this one cycle.
- Latency: the O_SND update and strobe occur 6 cycles after the tick cycle. With MIXER_DCBLOCK_EN it is 7 cycles.
- Input sampling: inputs are sampled only at the tick. Changes between ticks have no effect on the sample in progress.
- O_CLIP clears only on reset.
- O_SND holds its value between strobes.
- Reset asserted mid-sequence aborts it: no strobe is emitted and all outputs return to their reset values.

Optional Feature:
- Macro: MIXER_DCBLOCK_EN.
- When defined, a DCB state is inserted between SAT and IDLE.
  - It computes y = x - x_prev + y_prev - (y_prev >>> 8) in 18-bit signed arithmetic and saturates the result to 16 bits.
  - It then updates x_prev and y_prev, and O_SND/O_SND_STB are driven from DCB instead of SAT.
  - x_prev and y_prev reset to 0.
  - Under mute, x = 0 is fed so the filter decays cleanly.
- When undefined: no DCB state, no filter registers, and the 6-cycle latency applies.

Test Plan:
- Reset defaults: hold reset, then release; run 3 ticks with all inputs 0, gains 8, I_DIG=0x80 -> O_SND=0, a strobe every 1000 cycles exactly 6 cycles after the tick, O_CLIP=0.
- Unity gain: I_WAV0=1000, others 0, I_DIG=0x80, gains all 8 -> O_SND=1000.
- DIG offset: I_DIG=0x90, gain 8 -> O_SND=4096. Then gain 4 -> O_SND=2048.
- Saturation: I_WAV0=I_WAV1=I_WAV2=30000, gains 8 -> O_SND=32767 and O_CLIP=1. Then all inputs 0 -> O_SND=0 with O_CLIP still 1.
- Mute and mid-change: I_MUTE=1 with I_WAV0=20000 -> O_SND=0. Change I_WAV0 in the cycle after the tick -> the next strobe reflects the old value.
- Reset mid-sequence: assert reset 3 cycles after a tick -> no strobe, O_SND=0. (With MIXER_DCBLOCK_EN: a 16000 step input decays to |O_SND| < 2000 within 600 samples.)
